// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
// aes_key_schedule : runtime-selectable AES-128/192/256 key expansion with
//                    streamed and random-access round-key read-out
// Revision 1.0
// ============================================================================
module aes_key_schedule #(
   parameter int MAX_KEY_WIDTH = 256
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [MAX_KEY_WIDTH-1:0] key_i,
   input  logic [1:0]               key_mode_i,
   input  logic                     key_valid_i,
   output logic                     key_ready_o,
   output logic                     rk_valid_o,
   input  logic                     rk_ready_i,
   output logic [127:0]             rk_data_o,
   output logic [3:0]               rk_index_o,
   output logic                     rk_last_o,
   output logic [3:0]               nr_o,
   output logic                     done_o,
   input  logic [3:0]               rd_addr_i,
   output logic [127:0]             rd_data_o,
   output logic                     err_o
);

   localparam int         NK_MAX = MAX_KEY_WIDTH / 32;
   localparam int         NW_MAX = 4 * (NK_MAX + 7);
   localparam logic [3:0] NR_MAX = 4'(NK_MAX + 6);

   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXPAND = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   w [NW_MAX];
   logic [31:0]   key_word [NK_MAX];
   logic [5:0]    wi;
   logic [2:0]    pos;
   logic [7:0]    rcon;
   logic [3:0]    rnd, nr_q, nk_q;
   logic          err_q;
   logic [127:0]  rd_q, rd_word;
   logic          mode_ok, accept, load, expand_we;
   logic [3:0]    mode_nk, mode_nr;
   logic [5:0]    total;
   logic [31:0]   prev_w, back_w, sub_in, sub_out, new_w;

   for (genvar g = 0; g < NK_MAX; g++) begin : g_key_word
      assign key_word[g] = key_i[MAX_KEY_WIDTH-1-32*g -: 32];
   end

   always_comb begin
      mode_ok = 1'b0;
      mode_nk = 4'd4;
      mode_nr = 4'd10;
      case (key_mode_i)
         2'd0: mode_ok = (MAX_KEY_WIDTH >= 128);
         2'd1: begin mode_ok = (MAX_KEY_WIDTH >= 192); mode_nk = 4'd6; mode_nr = 4'd12; end
         2'd2: begin mode_ok = (MAX_KEY_WIDTH >= 256); mode_nk = 4'd8; mode_nr = 4'd14; end
         default: mode_ok = 1'b0;
      endcase
   end

   assign total     = {nr_q + 4'd1, 2'b00};
   assign expand_we = (state_q == S_EXPAND) && (wi < total);

   // Completion needs both the final word and the final handshake, whichever lands last.
   always_comb begin
      state_d     = state_q;
      key_ready_o = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            key_ready_o = 1'b1;
            if (key_valid_i && mode_ok) state_d = S_EXPAND;
         end
         S_EXPAND: if (wi == total && rnd > nr_q) state_d = S_DONE;
         default:  state_d = S_IDLE;
      endcase
   end

   assign accept = key_valid_i && key_ready_o;
   assign load   = accept && mode_ok;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      prev_w  = w[wi - 6'd1];
      back_w  = w[wi - {2'b00, nk_q}];
      sub_in  = (pos == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
      sub_out = sub_word(sub_in);
      if (pos == 3'd0)                       new_w = sub_out ^ {rcon, 24'h0} ^ back_w;
      else if (nk_q == 4'd8 && pos == 3'd4)  new_w = sub_out ^ back_w;
      else                                   new_w = prev_w ^ back_w;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int j = 0; j < NW_MAX; j++) w[j] <= '0;
      end else if (load) begin
         for (int j = 0; j < NK_MAX; j++)
            if (4'(j) < mode_nk) w[j] <= key_word[j];
      end else if (expand_we) begin
         w[wi] <= new_w;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wi    <= '0;
         pos   <= '0;
         rcon  <= '0;
         rnd   <= '0;
         nr_q  <= '0;
         nk_q  <= '0;
         err_q <= 1'b0;
         rd_q  <= '0;
      end else begin
         err_q <= accept && !mode_ok;
         rd_q  <= rd_word;
         if (load) begin
            wi   <= {2'b00, mode_nk};
            pos  <= '0;
            rcon <= 8'h01;
            rnd  <= '0;
            nr_q <= mode_nr;
            nk_q <= mode_nk;
         end else begin
            if (expand_we) begin
               wi   <= wi + 6'd1;
               pos  <= ({1'b0, pos} == nk_q - 4'd1) ? 3'd0 : pos + 3'd1;
               if (pos == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            if (rk_valid_o && rk_ready_i) rnd <= rnd + 4'd1;
         end
      end
   end

   // A round is streamable once its fourth word sits below the write pointer.
   always_comb begin
      rk_valid_o = (state_q == S_EXPAND) && (rnd <= nr_q) &&
                   ({1'b0, rnd, 2'b00} + 7'd4 <= {1'b0, wi});
      rk_data_o  = '0;
      if (rnd <= NR_MAX)
         rk_data_o = {w[{rnd, 2'b00}], w[{rnd, 2'b01}], w[{rnd, 2'b10}], w[{rnd, 2'b11}]};
      rd_word    = '0;
      if (rd_addr_i <= NR_MAX)
         rd_word = {w[{rd_addr_i, 2'b00}], w[{rd_addr_i, 2'b01}],
                    w[{rd_addr_i, 2'b10}], w[{rd_addr_i, 2'b11}]};
   end

   assign rk_index_o = rnd;
   assign rk_last_o  = (nr_q != 4'd0) && (rnd == nr_q);
   assign nr_o       = nr_q;
   assign done_o     = (state_q == S_DONE);
   assign rd_data_o  = rd_q;
   assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`default_nettype none
// ============================================================================
// tb_aes_key_schedule : known-answer table plus random keys against a
//                       behavioural key-expansion model
// Revision 1.0
// ============================================================================
module tb_aes_key_schedule;

   logic          clk = 1'b0;
   logic          resetn;
   logic [255:0]  key;
   logic [1:0]    key_mode;
   logic          key_valid, key_ready;
   logic          rk_valid, rk_ready, rk_last;
   logic [127:0]  rk_data, rd_data;
   logic [3:0]    rk_index, nr_out, rd_addr;
   logic          done, err;

   always #5 clk = ~clk;

   aes_key_schedule #(.MAX_KEY_WIDTH(256)) dut (
      .clk(clk), .resetn(resetn), .key_i(key), .key_mode_i(key_mode),
      .key_valid_i(key_valid), .key_ready_o(key_ready), .rk_valid_o(rk_valid),
      .rk_ready_i(rk_ready), .rk_data_o(rk_data), .rk_index_o(rk_index),
      .rk_last_o(rk_last), .nr_o(nr_out), .done_o(done), .rd_addr_i(rd_addr),
      .rd_data_o(rd_data), .err_o(err));

   int            vectors = 0;
   int            fails   = 0;
   logic [7:0]    sbox_t [256];
   logic [127:0]  m_rk  [15];
   logic [127:0]  st_rk [15];

   typedef struct {
      logic [1:0]    mode;
      logic [255:0]  key;
      logic [127:0]  last;
      int            done_cyc;
   } vec_t;
   vec_t tbl [3];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int k = 0; k < 8; k++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse in GF(2^8), then the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                     {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
   endfunction

   task automatic model_expand(input logic [255:0] k, input int nk);
      logic [31:0] wd [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int          nw;
      rc = 8'h01;
      nw = 4 * (nk + 7);
      for (int i = 0; i < nk; i++) wd[i] = k[255-32*i -: 32];
      for (int i = nk; i < nw; i++) begin
         t = wd[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         wd[i] = wd[i-nk] ^ t;
      end
      for (int r = 0; r < nw / 4; r++) m_rk[r] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
   endtask

   task automatic check_reset_outputs();
      check("rst_key_ready", key_ready, 1);
      check("rst_rk_valid",  rk_valid, 0);
      check("rst_rk_data",   rk_data, 0);
      check("rst_rk_index",  rk_index, 0);
      check("rst_rk_last",   rk_last, 0);
      check("rst_nr",        nr_out, 0);
      check("rst_done",      done, 0);
      check("rst_rd_data",   rd_data, 0);
      check("rst_err",       err, 0);
   endtask

   // Issue one key, follow the stream to done_o; pct is rk_ready duty in percent.
   task automatic run_key(input logic [1:0] mode, input logic [255:0] k, input int pct,
                          input bit timing, input int exp_done);
      int nk, nr, next_r, cyc, hs_edge, e_prev, e_exp;
      bit stalled, finished;
      logic [127:0] held;
      nk = 4 + 2 * int'(mode);
      nr = nk + 6;
      model_expand(k, nk);
      next_r = 0; cyc = 0; hs_edge = -1; e_prev = -1;
      stalled = 1'b0; finished = 1'b0; held = '0;
      key = k; key_mode = mode; key_valid = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      check("ready_low_in_expand", key_ready, 0);
      check("nr_on_accept", nr_out, nr);
      while (!finished && cyc < 400) begin
         if (done) begin
            check("done_after_last_hs", cyc, hs_edge + 1);
            check("all_rounds_streamed", next_r, nr + 1);
            if (timing) check("done_cycle", cyc, exp_done);
            finished = 1'b1;
         end else begin
            if (stalled) begin
               check("stall_valid_held", rk_valid, 1);
               check("stall_data_stable", rk_data, held);
            end
            if (rk_valid) begin
               check("rk_index", rk_index, next_r);
               check("rk_data", rk_data, m_rk[(next_r > 14) ? 14 : next_r]);
               check("rk_last", rk_last, next_r == nr);
               if (timing) begin
                  e_exp = 4 * next_r + 4 - nk;
                  if (e_exp < e_prev + 1) e_exp = e_prev + 1;
                  if (e_exp < 0) e_exp = 0;
                  check("rk_valid_cycle", cyc, e_exp);
                  e_prev = e_exp;
               end
            end
            rk_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            stalled  = 1'b0;
            if (rk_valid && rk_ready) begin
               if (next_r < 15) st_rk[next_r] = rk_data;
               hs_edge = cyc + 1;
               next_r++;
            end else if (rk_valid) begin
               stalled = 1'b1;
               held    = rk_data;
            end
            @(posedge clk); #1;
            cyc++;
         end
      end
      if (!finished) begin
         vectors++;
         fails++;
         $display("FAIL run_timeout: done_o got 0, expected 1 within 400 cycles");
      end
      rk_ready = 1'b1;
   endtask

   task automatic rd_sweep(input int nr);
      for (int a = 0; a <= nr; a++) begin
         rd_addr = 4'(a);
         @(posedge clk); #1;
         check("rd_data", rd_data, m_rk[a]);
         if (a == 5) check("rd_vs_stream_r5", rd_data, st_rk[5]);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] rk;
      logic [1:0]   rm;
      int           nr;
      resetn = 1'b0; key = '0; key_mode = 2'd0; key_valid = 1'b0;
      rk_ready = 1'b1; rd_addr = 4'd0;
      build_sbox();
      tbl[0] = '{2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5},
                 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 42};
      tbl[1] = '{2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0123456789abcdef},
                 128'he98ba06f448c773c8ecc720401002202, 48};
      tbl[2] = '{2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                 128'hfe4890d1e6188d0b046df344706c631e, 54};

      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs();

      // reserved mode while idle
      key_mode = 2'd3; key_valid = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      check("err_pulse_idle", err, 1);
      check("idle_after_err", key_ready, 1);
      check("no_valid_after_err", rk_valid, 0);
      check("nr_after_err", nr_out, 0);
      @(posedge clk); #1;
      check("err_one_cycle", err, 0);
      check("still_no_valid", rk_valid, 0);

      for (int v = 0; v < 3; v++) begin
         nr = 10 + 2 * int'(tbl[v].mode);
         run_key(tbl[v].mode, tbl[v].key, 100, 1'b1, tbl[v].done_cyc);
         check("known_last_round", st_rk[nr], tbl[v].last);
         rd_sweep(nr);
      end

      // reserved mode while done: only err moves
      key_mode = 2'd3; key_valid = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      check("err_pulse_done", err, 1);
      check("done_kept", done, 1);
      check("nr_kept", nr_out, 14);
      check("rd_kept", rd_data, m_rk[nr_out]);

      run_key(2'd2, tbl[2].key, 30, 1'b0, 0);
      check("backpressure_r14", st_rk[14], tbl[2].last);

      for (int n = 0; n < 6; n++) begin
         rm = 2'($urandom_range(0, 2));
         rk = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
         run_key(rm, rk, (n < 3) ? 30 : int'($urandom_range(15, 95)), 1'b0, 0);
      end

      // reset in the middle of an AES-256 expansion
      key = tbl[2].key; key_mode = 2'd2; key_valid = 1'b1; rk_ready = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("busy_before_reset", key_ready, 0);
      resetn = 1'b0;
      #1;
      check_reset_outputs();
      @(posedge clk); #1;
      resetn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("no_rk_after_reset", rk_valid, 0);
      end
      run_key(2'd0, tbl[0].key, 100, 1'b1, tbl[0].done_cyc);
      check("r10_after_reset", st_rk[10], tbl[0].last);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
`default_nettype wire
